// File: rtl/rng_floor_gen.sv
// Galois LFSR random source with seed loading, clock enable and lock-up recovery,
// plus a request/valid port returning unbiased floor numbers by bounded rejection sampling.
`timescale 1ns/1ps
module rng_floor_gen #(
  parameter int unsigned       WIDTH     = 12,
  parameter logic [WIDTH-1:0]  TAPS      = 12'h829,
  parameter logic [WIDTH-1:0]  SEED      = 12'hACE,
  parameter int unsigned       RANGE     = 6,
  parameter int unsigned       MAX_TRIES = 16,
  localparam int unsigned      OUT_W     = $clog2(RANGE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic [WIDTH-1:0] randy,
  output logic [OUT_W-1:0] draw_val,
  output logic             draw_valid,
  output logic             busy,
  output logic             fallback
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [TRY_W-1:0] tries_q;
  logic [OUT_W-1:0] draw_val_q;
  logic             draw_valid_q, busy_q, fallback_q;
  logic [OUT_W-1:0] cand_s, fb_val_s;
  logic             cand_ok_s, last_try_s;

  // Candidate is the low bits of the pre-step LFSR value; the fallback folds it back into range
  assign cand_s     = lfsr_q[OUT_W-1:0];
  assign cand_ok_s  = (32'(cand_s) < RANGE);
  assign fb_val_s   = OUT_W'(32'(cand_s) - RANGE);
  assign last_try_s = (tries_q == TRY_W'(MAX_TRIES - 1));

  // LFSR next state: seed load wins, an all-zero state is forced back to SEED, else step on en
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_ld) begin
      lfsr_d = (seed_in == {WIDTH{1'b0}}) ? SEED : seed_in;
    end else if (lfsr_q == {WIDTH{1'b0}}) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register and draw FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q       <= SEED;
      state_q      <= IDLE;
      tries_q      <= {TRY_W{1'b0}};
      draw_val_q   <= {OUT_W{1'b0}};
      draw_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      fallback_q   <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      draw_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && req) begin
            state_q <= DRAW;
            tries_q <= {TRY_W{1'b0}};
            busy_q  <= 1'b1;
          end
        end
        DRAW: begin
          if (en) begin
            if (cand_ok_s) begin
              draw_val_q   <= cand_s;
              fallback_q   <= 1'b0;
              draw_valid_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else if (last_try_s) begin
              draw_val_q   <= fb_val_s;
              fallback_q   <= 1'b1;
              draw_valid_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              tries_q <= tries_q + TRY_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign randy      = lfsr_q;
  assign draw_val   = draw_val_q;
  assign draw_valid = draw_valid_q;
  assign busy       = busy_q;
  assign fallback   = fallback_q;

endmodule

// File: tb/tb_rng_floor_gen.sv
// Self-checking bench: behavioural draw model compared every cycle, plus literal
// expectations from hand-stepped LFSR sequences and a MAX_TRIES=1 instance.
`timescale 1ns/1ps
module tb_rng_floor_gen;

  logic        clk = 1'b0;
  logic        rst, en, seed_ld, req;
  logic [11:0] seed_in;
  logic [11:0] randy;
  logic [2:0]  draw_val;
  logic        draw_valid, busy, fallback;

  logic        en2, seed_ld2, req2;
  logic [11:0] seed_in2;
  logic [11:0] randy2;
  logic [2:0]  draw_val2;
  logic        draw_valid2, busy2, fallback2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int pulses;

  rng_floor_gen dut (
    .clk(clk), .rst(rst), .en(en), .seed_ld(seed_ld), .seed_in(seed_in), .req(req),
    .randy(randy), .draw_val(draw_val), .draw_valid(draw_valid), .busy(busy), .fallback(fallback)
  );

  rng_floor_gen #(.MAX_TRIES(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .seed_ld(seed_ld2), .seed_in(seed_in2), .req(req2),
    .randy(randy2), .draw_val(draw_val2), .draw_valid(draw_valid2), .busy(busy2), .fallback(fallback2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] lfsr_next(input logic [11:0] x);
    return x[0] ? ((x >> 1) ^ 12'h829) : (x >> 1);
  endfunction

  // Reference model: a draw keeps pulling low 3 bits until one is below 6, up to 16 tries
  logic [11:0] m_lfsr;
  int          m_tries, m_val, m_c;
  bit          m_busy, m_valid, m_fb;
  assign m_c = int'(m_lfsr % 12'd8);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= 12'hACE; m_busy <= 1'b0; m_tries <= 0;
      m_val <= 0; m_valid <= 1'b0; m_fb <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (en && req) begin m_busy <= 1'b1; m_tries <= 0; end
      end else if (en) begin
        if (m_c < 6) begin
          m_val <= m_c; m_fb <= 1'b0; m_valid <= 1'b1; m_busy <= 1'b0;
        end else if (m_tries + 1 == 16) begin
          m_val <= m_c - 6; m_fb <= 1'b1; m_valid <= 1'b1; m_busy <= 1'b0;
        end else begin
          m_tries <= m_tries + 1;
        end
      end
      if (seed_ld)             m_lfsr <= (seed_in == 12'h000) ? 12'hACE : seed_in;
      else if (m_lfsr == 12'h0) m_lfsr <= 12'hACE;
      else if (en)             m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_randy",      32'(randy),      32'(m_lfsr));
      chk("m_draw_val",   32'(draw_val),   32'(m_val));
      chk("m_draw_valid", 32'(draw_valid), 32'(m_valid));
      chk("m_busy",       32'(busy),       32'(m_busy));
      chk("m_fallback",   32'(fallback),   32'(m_fb));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; seed_ld = 1'b0; seed_in = 12'h000; req = 1'b0;
    en2 = 1'b0; seed_ld2 = 1'b0; seed_in2 = 12'h000; req2 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_randy", 32'(randy), 32'h0ACE);
    chk("rst_val",   32'(draw_val), 32'h0);
    chk("rst_valid", 32'(draw_valid), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_fb",    32'(fallback), 32'h0);
    chk_on = 1'b1;

    // LFSR sequence and full period
    rst = 1'b1; en = 1'b1;
    step(); chk("seq1", 32'(randy), 32'h0567);
    step(); chk("seq2", 32'(randy), 32'h0A9A);
    step(); chk("seq3", 32'(randy), 32'h054D);
    for (int i = 3; i < 4095; i++) begin
      step();
      chk("nonzero", 32'(randy == 12'h000), 32'h0);
      if (i < 4094) chk("no_early_wrap", 32'(randy == 12'hACE), 32'h0);
    end
    chk("period", 32'(randy), 32'h0ACE);

    // First draw after reset: reject 7, accept 2
    reset_pulse();
    req = 1'b1; en = 1'b1;
    step(); chk("d_randy1", 32'(randy), 32'h0567); chk("d_busy1", 32'(busy), 32'h1);
    req = 1'b0;
    step(); chk("d_busy2", 32'(busy), 32'h1); chk("d_valid2", 32'(draw_valid), 32'h0);
    step(); chk("d_valid3", 32'(draw_valid), 32'h1); chk("d_val3", 32'(draw_val), 32'h2);
    chk("d_fb3", 32'(fallback), 32'h0); chk("d_busy3", 32'(busy), 32'h0);
    step(); chk("d_valid4", 32'(draw_valid), 32'h0); chk("d_val4", 32'(draw_val), 32'h2);

    // Stall mid-draw: everything frozen, same result on resume
    reset_pulse();
    req = 1'b1; en = 1'b1;
    step(); req = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_randy", 32'(randy), 32'h0567);
      chk("st_busy",  32'(busy), 32'h1);
      chk("st_valid", 32'(draw_valid), 32'h0);
    end
    en = 1'b1;
    step(); chk("st_rej", 32'(randy), 32'h0A9A); chk("st_busy2", 32'(busy), 32'h1);
    step(); chk("st_valid2", 32'(draw_valid), 32'h1); chk("st_val2", 32'(draw_val), 32'h2);

    // Seed loading, including zero substitution and the 0x001 step
    seed_ld = 1'b1; seed_in = 12'h000; en = 1'b0;
    step(); chk("seed_zero", 32'(randy), 32'h0ACE);
    seed_in = 12'h001;
    step(); chk("seed_one", 32'(randy), 32'h0001);
    seed_ld = 1'b0; en = 1'b1;
    step(); chk("seed_step", 32'(randy), 32'h0829);

    // Async reset mid-draw
    req = 1'b1;
    step(); req = 1'b0;
    chk("ar_busy_pre", 32'(busy), 32'h1);
    #2; rst = 1'b0; #1;
    chk("ar_randy", 32'(randy), 32'h0ACE);
    chk("ar_busy",  32'(busy), 32'h0);
    chk("ar_val",   32'(draw_val), 32'h0);
    chk("ar_valid", 32'(draw_valid), 32'h0);
    chk("ar_fb",    32'(fallback), 32'h0);
    @(negedge clk); rst = 1'b1;

    // Request while busy is ignored
    pulses = 0;
    req = 1'b1;
    step(); if (draw_valid) pulses++;
    step(); if (draw_valid) pulses++;
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); if (draw_valid) pulses++;
    end
    chk("one_pulse", 32'(pulses), 32'h1);

    // MAX_TRIES=1 instance: same-edge seed+req, candidate 7 falls back to 1
    seed_ld2 = 1'b1; seed_in2 = 12'h007; req2 = 1'b1; en2 = 1'b1;
    step(); chk("fb_randy", 32'(randy2), 32'h0007); chk("fb_busy", 32'(busy2), 32'h1);
    seed_ld2 = 1'b0; req2 = 1'b0;
    step();
    chk("fb_valid", 32'(draw_valid2), 32'h1); chk("fb_val", 32'(draw_val2), 32'h1);
    chk("fb_flag", 32'(fallback2), 32'h1); chk("fb_busy2", 32'(busy2), 32'h0);
    step(); chk("fb_valid_off", 32'(draw_valid2), 32'h0); chk("fb_hold", 32'(fallback2), 32'h1);
    en2 = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      req     = ($urandom_range(0, 9) < 3);
      seed_ld = ($urandom_range(0, 99) < 3);
      seed_in = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      step();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
